two_ch_rr_arbiter: RTL and testbench
====================================

# two_ch_rr_arbiter

Two-channel round-robin stream arbiter with a single registered output stage. It accepts words from channels A and B over valid/ready handshakes and forwards one word per cycle downstream. It exports the grant of the word currently held as `sel`, which directly drives the select of the downstream 2:1 data mux. A and B data are carried on the same port widths, so a word tagged with `sel` is steered there consistently.

## Interface
- `DATA_WIDTH`, 4, width of each channel's data word
- `CNT_WIDTH`, 8, width of each per-channel grant counter (saturating)

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `a_valid`  in  1  channel A word available
- `a_data`  in  DATA_WIDTH  channel A word
- `a_ready`  out  1  channel A word accepted this cycle when high with `a_valid`
- `b_valid`  in  1  channel B word available
- `b_data`  in  DATA_WIDTH  channel B word
- `b_ready`  out  1  channel B word accepted this cycle when high with `b_valid`
- `y_valid`  out  1  output register holds a word
- `y_data`  out  DATA_WIDTH  held word
- `y_ready`  in  1  downstream accepts held word
- `sel`  out  1  source of held word: 0 = A, 1 = B; drives downstream mux select
- `a_cnt`  out  CNT_WIDTH  words accepted from A since reset, saturates at all-ones
- `b_cnt`  out  CNT_WIDTH  words accepted from B since reset, saturates at all-ones

## Operation
- `load_en` = `!y_valid | y_ready` (output empty, or draining this cycle).
- Grant, combinational from `a_valid`, `b_valid`, `last`:
  - only A valid -> A
  - only B valid -> B
  - both valid -> the channel opposite `last`
  - neither -> no grant
- `a_ready` = `load_en & grant==A & a_valid`; `b_ready` likewise. Never both high. Ready never asserted while output is full and not draining.
- On accept (any ready high):
  - `y_data` <= granted data
  - `y_valid` <= 1
  - `sel` <= granted channel
  - `last` <= granted channel
  - that channel's counter increments unless all-ones
- On drain without accept (`y_valid & y_ready`, no input valid): `y_valid` <= 0. `y_data` and `sel` hold their last values.
- Held word (`y_data`, `sel`) is stable while `y_valid & !y_ready`.
- `last` updates only on accept, never on idle cycles. Fairness: under continuous dual requests, grants strictly alternate.
- Inputs must hold `valid` and `data` until accepted. The block does not check this.

## Timing
- Reset (`rst_n` low at a rising edge), all registers:
  - `y_valid`=0, `y_data`=0, `sel`=0
  - `last`=1, so A wins the first tie
  - `a_cnt`=0, `b_cnt`=0
- During the reset cycle, `a_ready`/`b_ready` evaluate low (`y_valid` treated as 0 but accept suppressed while `rst_n`=0).
- Reset mid-transfer discards the held word. Reset dominates a simultaneous accept.
- Latency: a word accepted at edge N appears with `y_valid`=1 after edge N.
- Throughput: 1 word/cycle with `y_ready` held high. A simultaneous drain and accept in the same cycle incurs no bubble.
- `y_ready` low with output full: both readies low; no counter changes.
- Counter at all-ones plus accept: stays all-ones. No wrap.
- Readies are combinational from `y_valid`, `y_ready`, input valids and `last`. There is no combinational path from data inputs to any output.

## Test plan
- Reset: drive `rst_n`=0 for 2 cycles with `a_valid`=`b_valid`=1. Expect readies 0 during reset. After release: `y_valid`=0, `sel`=0, counters 0.
- Single channel stream: `a_valid`=1 with `a_data`=3,5,7 on successive accepts, `y_ready`=1. Expect `y_data` 3,5,7 on consecutive cycles, `sel`=0, `a_cnt`=3.
- Contention: both valid continuously, `a_data`=4'hA, `b_data`=4'hB, `y_ready`=1 for 6 cycles. Expect `sel` 0,1,0,1,0,1 and `y_data` A,B,A,B,A,B; `a_cnt`=`b_cnt`=3.
- Back-pressure: output holds 4'h9 from B, `y_ready`=0 for 3 cycles with A valid. Expect `y_data`=9 and `sel`=1 stable, `a_ready`=0. Then `y_ready`=1: A accepted same cycle, next `y_data`=A word with `sel`=0.
- Saturation: `CNT_WIDTH`=2, 5 accepts from B. Expect `b_cnt` 1,2,3,3,3.
- Reset mid-operation: `rst_n`=0 while `y_valid`=1 and `b_valid`=1. Expect next cycle `y_valid`=0 and `b_cnt`=0. The next tie grants A.

Source files
------------

// File: rtl/two_ch_rr_arbiter.sv
// Purpose: two-channel round-robin stream arbiter feeding one registered output word.
// Latency: a word accepted at a rising edge is presented on y_data/y_valid right after that edge.
// Backpressure: both readies drop while the output holds a word and y_ready is low; a drain and an accept share a cycle.
//
// Ports:
//   clk, rst_n            clock and synchronous active-low reset
//   a_valid/a_data/a_ready   channel A valid/ready input stream
//   b_valid/b_data/b_ready   channel B valid/ready input stream
//   y_valid/y_data/y_ready   registered output stream
//   sel                   source of the held word (0 = A, 1 = B), drives the downstream mux select
//   a_cnt, b_cnt          saturating per-channel accept counters
module two_ch_rr_arbiter #(
    parameter int DATA_WIDTH = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_valid,
    input  logic [DATA_WIDTH-1:0] a_data,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  b_ready,
    output logic                  y_valid,
    output logic [DATA_WIDTH-1:0] y_data,
    input  logic                  y_ready,
    output logic                  sel,
    output logic [CNT_WIDTH-1:0]  a_cnt,
    output logic [CNT_WIDTH-1:0]  b_cnt
);

    localparam logic CH_A = 1'b0;
    localparam logic CH_B = 1'b1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    // Channel granted most recently; reset to B so A wins the first tie.
    logic last;

    logic load_en;
    logic grant;
    logic accept;
    logic [DATA_WIDTH-1:0] grant_data;

    // The output slot can take a new word when it is empty or being drained now.
    assign load_en = !y_valid || y_ready;

    always_comb begin
        grant = CH_A;
        if (a_valid && b_valid) begin
            // Tie: the channel that did not win last time goes next.
            grant = ~last;
        end else if (b_valid) begin
            grant = CH_B;
        end
    end

    // Reset gates the accept so no word is taken (and no counter moves) in a reset cycle.
    assign accept  = rst_n && load_en && (a_valid || b_valid);
    assign a_ready = accept && (grant == CH_A);
    assign b_ready = accept && (grant == CH_B);

    assign grant_data = (grant == CH_B) ? b_data : a_data;

    // Output stage and arbitration history.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_valid <= 1'b0;
            y_data  <= '0;
            sel     <= CH_A;
            last    <= CH_B;
        end else if (accept) begin
            y_valid <= 1'b1;
            y_data  <= grant_data;
            sel     <= grant;
            last    <= grant;
        end else if (y_ready) begin
            // Drain with nothing to replace it: data and sel keep their last values.
            y_valid <= 1'b0;
        end
    end

    // Saturating accept counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_cnt <= '0;
            b_cnt <= '0;
        end else begin
            if (a_ready && (a_cnt != CNT_MAX)) begin
                a_cnt <= a_cnt + CNT_ONE;
            end
            if (b_ready && (b_cnt != CNT_MAX)) begin
                b_cnt <= b_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_two_ch_rr_arbiter.sv
// Purpose: self-checking bench for two_ch_rr_arbiter (default counters plus a 2-bit counter instance).
// Latency: expected words are queued when the input handshake is driven and popped when the output shows them.
// Backpressure: y_ready is driven per scenario; stalls are checked for a stable held word.
module tb_two_ch_rr_arbiter;

    localparam int DW = 4;

    logic          clk;
    logic          rst_n;
    logic          a_valid, b_valid, y_ready;
    logic [DW-1:0] a_data, b_data;

    logic          a_ready, b_ready, y_valid, sel;
    logic [DW-1:0] y_data;
    logic [7:0]    a_cnt, b_cnt;

    logic          s_a_ready, s_b_ready, s_y_valid, s_sel;
    logic [DW-1:0] s_y_data;
    logic [1:0]    s_a_cnt, s_b_cnt;

    // Expected output words as {sel, data}.
    logic [DW:0] exp_q[$];
    logic [DW:0] exp_w;

    int n_checks;
    int n_fail;

    two_ch_rr_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .y_valid(y_valid), .y_data(y_data), .y_ready(y_ready),
        .sel(sel), .a_cnt(a_cnt), .b_cnt(b_cnt)
    );

    two_ch_rr_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_data(a_data), .a_ready(s_a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(s_b_ready),
        .y_valid(s_y_valid), .y_data(s_y_data), .y_ready(y_ready),
        .sel(s_sel), .a_cnt(s_a_cnt), .b_cnt(s_b_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic apply_reset();
        rst_n   = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        y_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        a_valid = 1'b1;
        b_valid = 1'b1;
        a_data  = 4'h1;
        b_data  = 4'h2;
        y_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if ({a_ready, b_ready} !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_ready: got a_ready/b_ready=%b%b, expected 00", a_ready, b_ready);
            end
        end
        rst_n   = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        #1;
        n_checks++;
        if ({y_valid, sel, a_cnt, b_cnt} !== {1'b0, 1'b0, 8'd0, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_state: got y_valid=%b sel=%b a_cnt=%0d b_cnt=%0d, expected 0 0 0 0",
                     y_valid, sel, a_cnt, b_cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_single_stream();
        logic [DW-1:0] vals [3];
        vals[0] = 4'd3;
        vals[1] = 4'd5;
        vals[2] = 4'd7;
        y_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_valid = 1'b1;
            a_data  = vals[i];
            exp_q.push_back({1'b0, vals[i]});
            #1;
            n_checks++;
            if (a_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_ready: got a_ready=%b, expected 1", a_ready);
            end
            @(negedge clk);
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL stream_out: no word expected, got y_data=%h", y_data);
            end else begin
                exp_w = exp_q.pop_front();
                if ({y_valid, sel, y_data} !== {1'b1, exp_w}) begin
                    n_fail++;
                    $display("FAIL stream_out: got valid=%b sel=%b data=%h, expected 1 %b %h",
                             y_valid, sel, y_data, exp_w[DW], exp_w[DW-1:0]);
                end
            end
        end
        a_valid = 1'b0;
        n_checks++;
        if (a_cnt !== 8'd3) begin
            n_fail++;
            $display("FAIL stream_cnt: got a_cnt=%0d, expected 3", a_cnt);
        end
        @(negedge clk);
        n_checks++;
        if ({y_valid, sel, y_data} !== {1'b0, 1'b0, 4'd7}) begin
            n_fail++;
            $display("FAIL stream_drain: got valid=%b sel=%b data=%h, expected 0 0 7", y_valid, sel, y_data);
        end
    endtask

    task automatic test_contention();
        apply_reset();
        a_valid = 1'b1;
        b_valid = 1'b1;
        a_data  = 4'hA;
        b_data  = 4'hB;
        y_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            logic pick_b;
            pick_b = (i % 2) == 1;
            exp_q.push_back({pick_b, pick_b ? 4'hB : 4'hA});
            #1;
            n_checks++;
            if ({a_ready, b_ready} !== {~pick_b, pick_b}) begin
                n_fail++;
                $display("FAIL contention_ready: cycle %0d got a/b_ready=%b%b, expected %b%b",
                         i, a_ready, b_ready, ~pick_b, pick_b);
            end
            @(negedge clk);
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL contention_out: no word expected, got y_data=%h", y_data);
            end else begin
                exp_w = exp_q.pop_front();
                if ({y_valid, sel, y_data} !== {1'b1, exp_w}) begin
                    n_fail++;
                    $display("FAIL contention_out: cycle %0d got valid=%b sel=%b data=%h, expected 1 %b %h",
                             i, y_valid, sel, y_data, exp_w[DW], exp_w[DW-1:0]);
                end
            end
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        n_checks++;
        if ({a_cnt, b_cnt} !== {8'd3, 8'd3}) begin
            n_fail++;
            $display("FAIL contention_cnt: got a_cnt=%0d b_cnt=%0d, expected 3 3", a_cnt, b_cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        b_valid = 1'b1;
        b_data  = 4'h9;
        y_ready = 1'b1;
        exp_q.push_back({1'b1, 4'h9});
        #1;
        n_checks++;
        if ({a_ready, b_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL bp_load_ready: got a/b_ready=%b%b, expected 01", a_ready, b_ready);
        end
        @(negedge clk);
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL bp_load_out: no word expected, got y_data=%h", y_data);
        end else begin
            exp_w = exp_q.pop_front();
            if ({y_valid, sel, y_data} !== {1'b1, exp_w}) begin
                n_fail++;
                $display("FAIL bp_load_out: got valid=%b sel=%b data=%h, expected 1 1 9", y_valid, sel, y_data);
            end
        end
        b_valid = 1'b0;
        y_ready = 1'b0;
        a_valid = 1'b1;
        a_data  = 4'h6;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if ({a_ready, b_ready, y_valid, sel, y_data, a_cnt} !== {2'b00, 1'b1, 1'b1, 4'h9, 8'd3}) begin
                n_fail++;
                $display("FAIL bp_stall: cycle %0d got rdy=%b%b valid=%b sel=%b data=%h a_cnt=%0d, expected 00 1 1 9 3",
                         i, a_ready, b_ready, y_valid, sel, y_data, a_cnt);
            end
            @(negedge clk);
        end
        y_ready = 1'b1;
        exp_q.push_back({1'b0, 4'h6});
        #1;
        n_checks++;
        if (a_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release_ready: got a_ready=%b, expected 1", a_ready);
        end
        @(negedge clk);
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL bp_release_out: no word expected, got y_data=%h", y_data);
        end else begin
            exp_w = exp_q.pop_front();
            if ({y_valid, sel, y_data} !== {1'b1, exp_w}) begin
                n_fail++;
                $display("FAIL bp_release_out: got valid=%b sel=%b data=%h, expected 1 0 6", y_valid, sel, y_data);
            end
        end
        a_valid = 1'b0;
        n_checks++;
        if ({a_cnt, b_cnt} !== {8'd4, 8'd4}) begin
            n_fail++;
            $display("FAIL bp_cnt: got a_cnt=%0d b_cnt=%0d, expected 4 4", a_cnt, b_cnt);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] sat_exp [5];
        sat_exp[0] = 2'd1;
        sat_exp[1] = 2'd2;
        sat_exp[2] = 2'd3;
        sat_exp[3] = 2'd3;
        sat_exp[4] = 2'd3;
        apply_reset();
        y_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            b_valid = 1'b1;
            b_data  = 4'(i + 1);
            exp_q.push_back({1'b1, 4'(i + 1)});
            #1;
            n_checks++;
            if ({b_ready, s_b_ready, s_a_ready} !== 3'b110) begin
                n_fail++;
                $display("FAIL sat_ready: cycle %0d got b_ready=%b sat b/a_ready=%b%b, expected 1 10",
                         i, b_ready, s_b_ready, s_a_ready);
            end
            @(negedge clk);
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sat_out: no word expected, got y_data=%h", y_data);
            end else begin
                exp_w = exp_q.pop_front();
                if ({y_valid, sel, y_data, s_y_valid, s_sel, s_y_data} !== {1'b1, exp_w, 1'b1, exp_w}) begin
                    n_fail++;
                    $display("FAIL sat_out: cycle %0d got %b/%b/%h sat %b/%b/%h, expected 1/%b/%h",
                             i, y_valid, sel, y_data, s_y_valid, s_sel, s_y_data, exp_w[DW], exp_w[DW-1:0]);
                end
            end
            n_checks++;
            if ({s_b_cnt, s_a_cnt, b_cnt} !== {sat_exp[i], 2'd0, 8'(i + 1)}) begin
                n_fail++;
                $display("FAIL sat_cnt: cycle %0d got sat b_cnt=%0d a_cnt=%0d wide b_cnt=%0d, expected %0d 0 %0d",
                         i, s_b_cnt, s_a_cnt, b_cnt, sat_exp[i], i + 1);
            end
        end
    endtask

    task automatic test_reset_mid();
        // Output is full and B is still requesting from the previous scenario.
        n_checks++;
        if ({y_valid, b_valid} !== 2'b11) begin
            n_fail++;
            $display("FAIL mid_setup: got y_valid=%b b_valid=%b, expected 1 1", y_valid, b_valid);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({a_ready, b_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_ready: got a/b_ready=%b%b during reset, expected 00", a_ready, b_ready);
        end
        @(negedge clk);
        exp_q.delete();
        n_checks++;
        if ({y_valid, b_cnt, s_b_cnt} !== {1'b0, 8'd0, 2'd0}) begin
            n_fail++;
            $display("FAIL mid_state: got y_valid=%b b_cnt=%0d sat b_cnt=%0d, expected 0 0 0", y_valid, b_cnt, s_b_cnt);
        end
        rst_n   = 1'b1;
        a_valid = 1'b1;
        b_valid = 1'b1;
        a_data  = 4'h2;
        b_data  = 4'h4;
        exp_q.push_back({1'b0, 4'h2});
        #1;
        n_checks++;
        if ({a_ready, b_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL mid_tie_ready: got a/b_ready=%b%b, expected 10", a_ready, b_ready);
        end
        @(negedge clk);
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL mid_tie_out: no word expected, got y_data=%h", y_data);
        end else begin
            exp_w = exp_q.pop_front();
            if ({y_valid, sel, y_data} !== {1'b1, exp_w}) begin
                n_fail++;
                $display("FAIL mid_tie_out: got valid=%b sel=%b data=%h, expected 1 0 2", y_valid, sel, y_data);
            end
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        a_valid  = 1'b0;
        b_valid  = 1'b0;
        a_data   = '0;
        b_data   = '0;
        y_ready  = 1'b0;
        test_reset();
        test_single_stream();
        test_contention();
        test_backpressure();
        test_saturation();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
